// File: rtl/wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mult_pipe
//   Pipelined WIDTH x WIDTH Wallace-tree multiplier with a valid/ready handshake
//   on both sides. Operands may be unsigned or two's-complement (Baugh-Wooley).
//
//   Stage 1 : operand registers (a_q, b_q)
//   Stage 2 : partial-product matrix + carry-save reduction -> (s_q, c_q)
//   Stage 3 : carry-propagate add -> P
//
//   All three stages advance together on adv = !out_valid | out_ready, so a
//   stalled consumer freezes the whole pipe and bubbles are never squeezed out.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   A/B valid this cycle
//   in_ready   operands accepted this cycle (equals adv)
//   A, B       multiplicand / multiplier, WIDTH bits
//   out_valid  P holds a product
//   out_ready  consumer takes P this cycle
//   P          product, 2*WIDTH bits, unsigned or two's-complement per SIGNED
// -----------------------------------------------------------------------------
module wallace_mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);

    localparam int PW    = 2 * WIDTH;
    // Signed mode carries one extra row holding the Baugh-Wooley constants.
    localparam int NROWS = (SIGNED != 0) ? WIDTH + 1 : WIDTH;

    // Row count after one 3:2 layer: every full group of three becomes two,
    // leftovers pass straight through.
    function automatic int rows_after(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    function automatic int rows_at(input int layer);
        int n;
        n = NROWS;
        for (int l = 0; l < layer; l++) n = rows_after(n);
        return n;
    endfunction

    function automatic int num_layers(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = rows_after(n);
            l++;
        end
        return l;
    endfunction

    localparam int NLAYERS = num_layers(NROWS);

    // Baugh-Wooley: a partial-product bit is complemented when exactly one of
    // its two operand bits is the sign bit.
    function automatic logic bw_inv(input int i, input int j);
        return (SIGNED != 0) && ((i == WIDTH - 1) != (j == WIDTH - 1));
    endfunction

    // -------------------------------------------------------------------------
    // Handshake / valid pipeline
    // -------------------------------------------------------------------------
    logic       adv;
    logic [2:0] vld_q;   // [0] stage 1, [1] stage 2, [2] stage 3

    assign out_valid = vld_q[2];
    assign adv       = !vld_q[2] || out_ready;
    assign in_ready  = adv;

    // -------------------------------------------------------------------------
    // Stage 1 registers and partial-product formation
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    pp   [WIDTH];
    logic [PW-1:0]    mat0 [NROWS];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (a_q[j] & b_q[i]) ^ bw_inv(i, j);
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_row
            assign mat0[i] = pp[i];
        end
        if (SIGNED != 0) begin : g_bw_const
            // +1 at column WIDTH and at column 2*WIDTH-1
            assign mat0[WIDTH] = {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Wallace reduction: each layer runs column-wise full adders over groups
    // of three rows; carries move one column up and drop off the top.
    // -------------------------------------------------------------------------
    generate
        for (genvar l = 0; l < NLAYERS; l++) begin : g_layer
            localparam int NI = rows_at(l);
            localparam int NG = NI / 3;
            localparam int NO = rows_after(NI);

            logic [PW-1:0] rin  [NI];
            logic [PW-1:0] rout [NO];

            if (l == 0) begin : g_src
                assign rin = mat0;
            end else begin : g_src
                assign rin = g_layer[l-1].rout;
            end

            for (genvar g = 0; g < NG; g++) begin : g_fa
                logic [PW-1:0] x, y, z;
                logic [PW-2:0] maj;
                assign x = rin[3*g];
                assign y = rin[3*g+1];
                assign z = rin[3*g+2];
                assign maj = (x[PW-2:0] & y[PW-2:0]) | (x[PW-2:0] & z[PW-2:0])
                           | (y[PW-2:0] & z[PW-2:0]);
                assign rout[2*g]   = x ^ y ^ z;
                assign rout[2*g+1] = {maj, 1'b0};
            end

            for (genvar r = 0; r < NI % 3; r++) begin : g_pass
                assign rout[2*NG + r] = rin[3*NG + r];
            end
        end
    endgenerate

    logic [PW-1:0] s_d, c_d;
    assign s_d = g_layer[NLAYERS-1].rout[0];
    assign c_d = g_layer[NLAYERS-1].rout[1];

    // -------------------------------------------------------------------------
    // Stage 2 / 3 registers
    // -------------------------------------------------------------------------
    logic [PW-1:0] s_q, c_q, p_q, p_d;
    assign p_d = s_q + c_q;
    assign P   = p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            p_q   <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[1:0], in_valid};
            a_q   <= A;
            b_q   <= B;
            s_q   <= s_d;
            c_q   <= c_d;
            p_q   <= p_d;
        end
    end

endmodule
